// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter in front of the write side of an 8-bit FIFO.
//   One producer at a time owns the FIFO write port and may push up to MAX_BURST
//   words before ownership rotates. A released owner gets lowest priority in the
//   next decision. Every grant change costs one IDLE cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; forces every output to 0 while high
//   req_valid    per-requester valid
//   req_data     requester i word at [i*DATA_W +: DATA_W]
//   req_ready    per-requester accept (valid & ready = word taken this cycle)
//   fifo_full    FIFO full flag
//   fifo_wr_en   FIFO write strobe (combinational, same cycle as accept)
//   fifo_data    FIFO write data, 0 when fifo_wr_en is low
//   grant_valid  an owner holds the port
//   grant_id     current owner, 0 when grant_valid is low
//   xfer_count   (FIFO_ARB_STATS_EN only) 16-bit saturating accepted-word count per
//                requester at [i*16 +: 16]
//
// Configuration
//   FIFO_ARB_STATS_EN  adds the xfer_count port and its counters.

module fifo_wr_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned ID_W      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wr_en,
   output logic [DATA_W-1:0]       fifo_data,
   output logic                    grant_valid,
   output logic [ID_W-1:0]         grant_id
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]     xfer_count
`endif
);

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e          state_q;
   logic [ID_W-1:0] owner_q;
   logic [ID_W-1:0] last_owner_q;
   logic [7:0]      burst_cnt_q;

   // Round-robin search starting just after the last owner
   logic            pick_found;
   logic [ID_W-1:0] pick_idx;
   logic [ID_W-1:0] cand;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         cand = ID_W'((int'(last_owner_q) + k) % int'(N_REQ));
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Owner's valid and data, selected with constant indices
   logic              owner_valid;
   logic [DATA_W-1:0] owner_data;

   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (owner_q == ID_W'(i)) begin
            owner_valid = req_valid[i];
            owner_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   logic own_active;
   logic xfer;
   logic burst_last;

   assign own_active = (state_q == StOwn) && !rst;
   assign xfer       = own_active && owner_valid && !fifo_full;
   assign burst_last = (burst_cnt_q == 8'(MAX_BURST - 1));

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         req_ready[i] = own_active && (owner_q == ID_W'(i)) && !fifo_full;
      end
   end

   assign fifo_wr_en  = xfer;
   assign fifo_data   = xfer ? owner_data : '0;
   assign grant_valid = own_active;
   assign grant_id    = own_active ? owner_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         last_owner_q <= ID_W'(N_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (pick_found) begin
                  owner_q     <= pick_idx;
                  state_q     <= StOwn;
                  burst_cnt_q <= '0;
               end
            end
            StOwn: begin
               // A full stall with valid held keeps the grant and the count
               if (!owner_valid || (xfer && burst_last)) begin
                  state_q      <= StIdle;
                  last_owner_q <= owner_q;
                  burst_cnt_q  <= '0;
               end else if (xfer) begin
                  burst_cnt_q <= burst_cnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] cnt_q [N_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (xfer && (owner_q == ID_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      xfer_count = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         xfer_count[i*16 +: 16] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed phases plus randomized traffic, every
// cycle compared against a transaction-level reference model.

module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int MAXB  = 4;
   localparam int IDW   = 2;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [DW-1:0]     fifo_data;
   logic              grant_valid;
   logic [IDW-1:0]    grant_id;
`ifdef FIFO_ARB_STATS_EN
   logic [N*16-1:0]   xfer_count;
`endif

   fifo_wr_arbiter #(
      .N_REQ    (N),
      .DATA_W   (DW),
      .MAX_BURST(MAXB),
      .ID_W     (IDW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_data  (fifo_data),
      .grant_valid(grant_valid),
      .grant_id   (grant_id)
`ifdef FIFO_ARB_STATS_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: who holds the port (-1 = nobody), how many words the grant
   // may still write, and who was served last (lowest priority next time).
   int          m_holder;
   int          m_left;
   int          m_prev;
   int          m_stat [N];
   logic [DW-1:0] cur_word [N];
   bit          popped [N];
   int          seq_ctr;

   // Compare DUT outputs against model for the current inputs
   task automatic check_cycle();
      bit            wr;
      logic [N-1:0]  rdy;
      logic [DW-1:0] dat;
      wr  = !rst && (m_holder >= 0) && req_valid[m_holder] && !fifo_full;
      rdy = '0;
      if (!rst && m_holder >= 0 && !fifo_full) rdy[m_holder] = 1'b1;
      dat = wr ? cur_word[m_holder] : '0;
      check_eq("grant_valid", 64'(grant_valid), 64'(!rst && m_holder >= 0));
      check_eq("grant_id", 64'(grant_id), (!rst && m_holder >= 0) ? 64'(m_holder) : 64'd0);
      check_eq("fifo_wr_en", 64'(fifo_wr_en), 64'(wr));
      check_eq("fifo_data", 64'(fifo_data), 64'(dat));
      check_eq("req_ready", 64'(req_ready), 64'(rdy));
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         check_eq("xfer_count", 64'(xfer_count[i*16 +: 16]), 64'(m_stat[i]));
      end
`endif
   endtask

   // Advance the model across the coming clock edge
   task automatic model_edge();
      bit wr;
      wr = !rst && (m_holder >= 0) && req_valid[m_holder] && !fifo_full;
      if (rst) begin
         m_holder = -1;
         m_left   = 0;
         m_prev   = N - 1;
         for (int i = 0; i < N; i++) m_stat[i] = 0;
      end else if (m_holder < 0) begin
         for (int k = 1; k <= N; k++) begin
            if (m_holder < 0 && req_valid[(m_prev + k) % N]) begin
               m_holder = (m_prev + k) % N;
               m_left   = MAXB;
            end
         end
      end else begin
         if (wr) begin
            popped[m_holder] = 1'b1;
            if (m_stat[m_holder] < 65535) m_stat[m_holder]++;
            m_left--;
         end
         if (!req_valid[m_holder] || m_left == 0) begin
            m_prev   = m_holder;
            m_holder = -1;
         end
      end
   endtask

   // Replace accepted words and repack the data bus (after the edge)
   task automatic refresh_data();
      for (int i = 0; i < N; i++) begin
         if (popped[i]) begin
            cur_word[i] = 8'($urandom);
            popped[i]   = 1'b0;
         end
         req_data[i*DW +: DW] = cur_word[i];
      end
   endtask

   task automatic cycle();
      refresh_data();
      @(negedge clk);
      check_cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '1;
      fifo_full = 1'b0;
      req_data  = '0;
      m_holder  = -1;
      m_left    = 0;
      m_prev    = N - 1;
      for (int i = 0; i < N; i++) begin
         m_stat[i]   = 0;
         popped[i]   = 1'b0;
         cur_word[i] = 8'(8'h10 * (i + 1));
      end
      @(posedge clk);
      #1;

      // Reset held with every requester valid
      repeat (2) cycle();
      rst = 1'b0;

      // All requesters continuously valid: 0,1,2,3,0... bursts of MAXB
      repeat (45) cycle();

      // Mid-burst reset, then only requester 2 with a counting data stream
      rst = 1'b1;
      cycle();
      rst       = 1'b0;
      req_valid = 4'b0100;
      seq_ctr   = 0;
      cur_word[2] = 8'hA0;
      for (int c = 0; c < 14; c++) begin
         cycle();
         if (popped[2]) begin
            seq_ctr++;
            cur_word[2] = 8'(8'hA0 + seq_ctr);
            popped[2]   = 1'b0;
         end
      end
      req_valid = '0;
      repeat (2) cycle();

      // Full stall in the middle of a burst
      req_valid = 4'b0010;
      repeat (3) cycle();
      fifo_full = 1'b1;
      repeat (3) cycle();
      fifo_full = 1'b0;
      repeat (4) cycle();

      // Owner 3 drops valid after one word while requester 0 waits
      req_valid = 4'b1000;
      repeat (2) cycle();
      req_valid = 4'b1001;
      cycle();
      req_valid = 4'b0001;
      repeat (3) cycle();

      // Randomized traffic with back-pressure and occasional resets
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 7);
         fifo_full = ($urandom_range(0, 9) < 2);
         rst       = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst       = 1'b0;
      fifo_full = 1'b0;
      req_valid = '0;
      repeat (2) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
